bot_line_ctrl: RTL

Line-following motor controller that closes the Rojobot loop. It consumes the synchronized system registers (Sensors, LocX, LocY) and the `upd_sysregs` toggle flag produced by the world interface, and drives the 8-bit motor control word that the world interface returns to the BOTSIM PicoBlaze on port 0. It makes one decision per BOTSIM update.

---
 rtl/bot_line_ctrl.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/bot_line_ctrl.sv
// Rojobot line-following motor controller. Makes one steering decision per
// BOTSIM register update, which is signalled by any change of upd_sysregs.
module bot_line_ctrl #(
    parameter logic [2:0] FWD_SPD        = 3'd5,
    parameter logic [2:0] TURN_SPD       = 3'd3,
    parameter logic [7:0] SEARCH_LIMIT   = 8'd40,
    parameter logic [7:0] BACKUP_UPDATES = 8'd4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic        upd_sysregs,
    input  logic [7:0]  Sensors,
    input  logic [7:0]  LocX,
    input  logic [7:0]  LocY,
    output logic [7:0]  MotCtl,
    output logic [2:0]  CtlState,
    output logic        Lost,
    output logic [15:0] EvtCount,
    output logic [15:0] LastLoc
);
    localparam int unsigned CNT_W = 8;
    localparam int unsigned EVT_W = 16;
    localparam int unsigned MOT_W = 8;

    localparam logic SIDE_LEFT  = 1'b0;
    localparam logic SIDE_RIGHT = 1'b1;

    // Motor words: {lm_spd, lm_dir, rm_spd, rm_dir}, dir 1 = forward
    localparam logic [MOT_W-1:0] MOT_OFF      = '0;
    localparam logic [MOT_W-1:0] MOT_STRAIGHT = {FWD_SPD, 1'b1, FWD_SPD, 1'b1};
    localparam logic [MOT_W-1:0] MOT_VEER_L   = {TURN_SPD, 1'b1, FWD_SPD, 1'b1};
    localparam logic [MOT_W-1:0] MOT_VEER_R   = {FWD_SPD, 1'b1, TURN_SPD, 1'b1};
    localparam logic [MOT_W-1:0] MOT_PIVOT_L  = {TURN_SPD, 1'b0, TURN_SPD, 1'b1};
    localparam logic [MOT_W-1:0] MOT_PIVOT_R  = {TURN_SPD, 1'b1, TURN_SPD, 1'b0};
    localparam logic [MOT_W-1:0] MOT_REVERSE  = {TURN_SPD, 1'b0, TURN_SPD, 1'b0};

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FOLLOW = 3'd1,
        S_SEARCH = 3'd2,
        S_BACKUP = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    state_t             state_q, state_d;
    logic [MOT_W-1:0]   mot_q, mot_d;
    logic               lost_q, lost_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               side_q, side_d;
    logic               upd_q;
    logic [EVT_W-1:0]   evt_cnt_q, evt_cnt_d;
    logic [EVT_W-1:0]   loc_q, loc_d;

    logic               evt;
    logic               prox;
    logic               line_seen;
    logic [MOT_W-1:0]   pivot_mot;
    state_t             fol_state;
    logic [MOT_W-1:0]   fol_mot;
    logic               fol_side;
    logic               sensors_unused;

    assign evt            = upd_sysregs ^ upd_q;
    assign prox           = Sensors[4] | Sensors[3];
    assign line_seen      = (Sensors[2:0] != 3'b111);
    assign pivot_mot      = (side_q == SIDE_RIGHT) ? MOT_PIVOT_R : MOT_PIVOT_L;
    assign sensors_unused = ^Sensors[7:5];

    // Line table shared by FOLLOW, IDLE start-up and SEARCH recovery
    always_comb begin
        fol_state = S_FOLLOW;
        fol_mot   = MOT_STRAIGHT;
        fol_side  = side_q;
        case (Sensors[2:0])
            3'b011: begin
                fol_mot  = MOT_VEER_L;
                fol_side = SIDE_LEFT;
            end
            3'b110: begin
                fol_mot  = MOT_VEER_R;
                fol_side = SIDE_RIGHT;
            end
            3'b111: begin
                fol_state = S_SEARCH;
                fol_mot   = pivot_mot;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        mot_d     = mot_q;
        lost_d    = lost_q;
        cnt_d     = cnt_q;
        side_d    = side_q;
        evt_cnt_d = evt ? evt_cnt_q + EVT_W'(1) : evt_cnt_q;
        loc_d     = evt ? {LocX, LocY} : loc_q;

        if (!enable) begin
            state_d = S_IDLE;
            mot_d   = MOT_OFF;
            cnt_d   = '0;
        end else if (evt) begin
            case (state_q)
                S_IDLE, S_FOLLOW: begin
                    if (state_q == S_IDLE) lost_d = 1'b0;
                    cnt_d = '0;
                    if (prox) begin
                        state_d = S_BACKUP;
                        mot_d   = MOT_REVERSE;
                    end else begin
                        state_d = fol_state;
                        mot_d   = fol_mot;
                        side_d  = fol_side;
                    end
                end
                S_SEARCH: begin
                    if (prox) begin
                        state_d = S_BACKUP;
                        mot_d   = MOT_REVERSE;
                        cnt_d   = '0;
                    end else if (line_seen) begin
                        state_d = fol_state;
                        mot_d   = fol_mot;
                        side_d  = fol_side;
                        cnt_d   = '0;
                    end else if (cnt_q == SEARCH_LIMIT - 8'd1) begin
                        state_d = S_STOP;
                        mot_d   = MOT_OFF;
                        lost_d  = 1'b1;
                    end else begin
                        mot_d = pivot_mot;
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                S_BACKUP: begin
                    if (cnt_q == BACKUP_UPDATES - 8'd1) begin
                        state_d = S_SEARCH;
                        mot_d   = pivot_mot;
                        cnt_d   = '0;
                    end else begin
                        mot_d = MOT_REVERSE;
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                S_STOP: mot_d = MOT_OFF;
                default: begin
                    state_d = S_IDLE;
                    mot_d   = MOT_OFF;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            mot_q     <= MOT_OFF;
            lost_q    <= 1'b0;
            cnt_q     <= '0;
            side_q    <= SIDE_LEFT;
            upd_q     <= 1'b0;
            evt_cnt_q <= '0;
            loc_q     <= '0;
        end else begin
            state_q   <= state_d;
            mot_q     <= mot_d;
            lost_q    <= lost_d;
            cnt_q     <= cnt_d;
            side_q    <= side_d;
            upd_q     <= upd_sysregs;
            evt_cnt_q <= evt_cnt_d;
            loc_q     <= loc_d;
        end
    end

    assign MotCtl   = mot_q;
    assign CtlState = state_q;
    assign Lost     = lost_q;
    assign EvtCount = evt_cnt_q;
    assign LastLoc  = loc_q;

endmodule
